clkdiv_multi: RTL and testbench
===============================

Name: clkdiv_multi

Overview:
Parametrised multi-channel clock-enable and divided-clock generator. It replaces the single-tap divider with a free-running counter and NCH independently programmable channels. Each channel has a one-cycle tick and a registered ~50% square output. A debounced single-step mode drives every channel from a push-button so board logic can be stepped by hand. It sits at the top of each lab design, feeding display scanning, FSM enables and slow visible clocks.

Parameters:
CNT_W, 32, width of free-running counter clkdiv
NCH, 4, number of divider channels
DIV_W, 27, width of each channel divisor
DEF_DIV, 67108864, reset divisor for every channel (ck period 2*DEF_DIV cycles)
DB_CYCLES, 16, consecutive stable synchronised samples required to accept a new button level (>=2)

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
sel_step  in  1  0 = run mode (divided), 1 = step mode (button)
pulse  in  1  raw, asynchronous, bouncing push-button
div_we  in  1  divisor write strobe
div_sel  in  clog2(NCH) (min 1)  channel addressed by div_we
div_val  in  DIV_W  new divisor value
clkdiv  out  CNT_W  free-running counter
tick  out  NCH  one-cycle enable per channel
ck  out  NCH  registered divided clock per channel
step_tick  out  1  one-cycle pulse per debounced button press

Behaviour:
- Reset (rst=1 at a rising edge):
  - clkdiv, tick, ck, step_tick, channel counters, pending flags and debounce state all clear to 0.
  - Every divisor reads DEF_DIV.
  - rst overrides every other input in that cycle; asserting it mid-period aborts the period with no extra tick.
- clkdiv: increments by 1 every cycle and wraps from 2^CNT_W-1 to 0. It is unaffected by mode.
- Channel i, run mode:
  - cnt_i counts 0..N_i-1. In the cycle cnt_i==N_i-1, tick[i] is registered high for exactly one cycle, ck[i] toggles and cnt_i returns to 0.
  - ck[i] period = 2*N_i cycles; tick[i] period = N_i cycles.
  - N_i=0 and N_i=1 both mean tick every cycle; ck[i] toggles every cycle.
- Divisor update:
  - div_we writes div_val to the pending register of channel div_sel and sets its pending flag.
  - The pending value becomes N_i only in the cycle cnt_i wraps to 0, so no period is truncated or stretched.
  - A second write before the wrap overwrites the pending value; last write wins.
  - A write in the same cycle as the wrap is applied at the next wrap.
  - div_sel >= NCH is ignored.
- Button path:
  - pulse passes through a 2-FF synchroniser.
  - The debounced level db changes only after DB_CYCLES consecutive cycles with the synchronised value different from db.
  - The db rising edge registers step_tick=1 for one cycle. Releases and bounces produce nothing.
  - The button path runs in both modes.
- Step mode (sel_step=1, registered to mode_q, takes effect 1 cycle later):
  - tick[i] = step_tick for all i; ck[i] toggles on each step_tick.
  - Channel counters freeze at their current value.
  - Pending divisors stay pending.
- Mode switch:
  - Run to step, and step to run: counters resume from their frozen values.
  - ck outputs are always flop outputs, so no glitch or runt pulse shorter than 1 cycle is possible at a switch.
- Latency:
  - tick/ck respond 1 cycle after the terminal count is reached.
  - step_tick asserts 2 sync cycles + DB_CYCLES + 1 cycle after a clean pulse rising edge.

Test Plan:
- Reset, then hold for 10 cycles with NCH=4 and DEF_DIV shrunk to 4 via parameter override -> clkdiv=0..9; tick[i] high on cycles 4 and 8 after reset release; ck[i] toggles at the same points (period 8).
- Write div_sel=1, div_val=3 while cnt_1=1 with N_1=4 -> current period completes at 4 cycles; subsequent tick[1] every 3 cycles. Channels 0, 2 and 3 are unchanged.
- Divisor 0 and divisor 1 on channel 2 -> tick[2] high every cycle; ck[2] toggles every cycle.
- sel_step=1 with DB_CYCLES=16: pulse bounces 0/1 every 3 cycles for 40 cycles, then stays 1 for 30 cycles -> exactly one step_tick and one tick on every channel; each ck toggles once; no ticks from channel counters meanwhile.
- Force clkdiv to 2^CNT_W-1 (CNT_W=8 override) -> next value 0; no effect on tick.
- Assert rst mid-period while a pending write exists -> all outputs 0; pending discarded; divisors back to DEF_DIV; first tick DEF_DIV cycles after rst release.

Source files
------------

// File: rtl/clkdiv_multi.sv
// Purpose : free-running counter plus NCH programmable clock-enable / divided-clock channels,
//           with a debounced push-button single-step mode that drives every channel by hand.
// Latency : tick/ck 1 cycle after terminal count; step_tick 2 sync + DB_CYCLES + 1 cycles after a clean press.
// Backpressure: none; free-running, outputs are never stalled.
// Ports   : clk, rst (sync, active-high); sel_step (0 run / 1 step); pulse (raw button);
//           div_we/div_sel/div_val (divisor write); clkdiv (counter); tick/ck (per channel); step_tick.
module clkdiv_multi #(
  parameter int CNT_W     = 32,
  parameter int NCH       = 4,
  parameter int DIV_W     = 27,
  parameter int DEF_DIV   = 67108864,
  parameter int DB_CYCLES = 16,
  localparam int SEL_W    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sel_step,
  input  logic             pulse,
  input  logic             div_we,
  input  logic [SEL_W-1:0] div_sel,
  input  logic [DIV_W-1:0] div_val,
  output logic [CNT_W-1:0] clkdiv,
  output logic [NCH-1:0]   tick,
  output logic [NCH-1:0]   ck,
  output logic             step_tick
);

  localparam int DB_W = $clog2(DB_CYCLES);
  localparam logic [DIV_W-1:0] DEF_N = DIV_W'(DEF_DIV);

  logic            mode_q;
  logic            sync1, sync2;
  logic            db, db_d;
  logic [DB_W-1:0] db_cnt;
  logic            step_fire;

  logic [DIV_W-1:0] cnt    [NCH];
  logic [DIV_W-1:0] n_cur  [NCH];
  logic [DIV_W-1:0] n_pend [NCH];
  logic [NCH-1:0]   pend_vld;
  logic [NCH-1:0]   term;
  logic [NCH-1:0]   wr_hit;

  // Rising edge of the debounced level; tick and step_tick both register it,
  // so in step mode every tick lines up exactly with step_tick.
  assign step_fire = db & ~db_d;

  always_comb begin
    term   = '0;
    wr_hit = '0;
    for (int i = 0; i < NCH; i++) begin
      // Divisors 0 and 1 both mean "every cycle".
      term[i]   = (n_cur[i] <= DIV_W'(1)) || (cnt[i] == n_cur[i] - DIV_W'(1));
      // A div_sel at or above NCH matches no channel and is dropped.
      wr_hit[i] = div_we && (32'(div_sel) == i);
    end
  end

  // Counter, mode register and button path.
  always_ff @(posedge clk) begin
    if (rst) begin
      clkdiv    <= '0;
      mode_q    <= 1'b0;
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      db        <= 1'b0;
      db_d      <= 1'b0;
      db_cnt    <= '0;
      step_tick <= 1'b0;
    end else begin
      clkdiv    <= clkdiv + CNT_W'(1);
      mode_q    <= sel_step;
      sync1     <= pulse;
      sync2     <= sync1;
      db_d      <= db;
      step_tick <= step_fire;
      // db follows sync2 only after DB_CYCLES consecutive disagreeing samples;
      // any agreeing sample restarts the count.
      if (sync2 != db) begin
        if (db_cnt == DB_W'(DB_CYCLES - 1)) begin
          db     <= sync2;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + DB_W'(1);
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  // Channels.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick     <= '0;
      ck       <= '0;
      pend_vld <= '0;
      for (int i = 0; i < NCH; i++) begin
        cnt[i]    <= '0;
        n_cur[i]  <= DEF_N;
        n_pend[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (mode_q) begin
          // Step mode: counters freeze, pending divisors wait for run mode.
          tick[i] <= step_fire;
          if (step_fire) ck[i] <= ~ck[i];
        end else begin
          tick[i] <= term[i];
          if (term[i]) begin
            ck[i]  <= ~ck[i];
            cnt[i] <= '0;
            // New divisor only lands on a period boundary.
            if (pend_vld[i]) n_cur[i] <= n_pend[i];
          end else begin
            cnt[i] <= cnt[i] + DIV_W'(1);
          end
        end
        // A write wins over the clear, so a write landing on the wrap cycle
        // stays pending for the following wrap.
        if (wr_hit[i]) begin
          n_pend[i]   <= div_val;
          pend_vld[i] <= 1'b1;
        end else if (!mode_q && term[i]) begin
          pend_vld[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_clkdiv_multi.sv
// Bench for clkdiv_multi: directed phases followed by random stimulus, all
// outputs compared every cycle against a behavioural model of the channel,
// counter and button rules.
module tb_clkdiv_multi;

  localparam int CW   = 8;
  localparam int NCH  = 4;
  localparam int DW   = 8;
  localparam int DEF  = 4;
  localparam int DB   = 16;
  localparam int SW   = 2;
  localparam int MAXC = 4096;

  logic          clk = 1'b0;
  logic          rst, sel_step, pulse, div_we;
  logic [SW-1:0] div_sel;
  logic [DW-1:0] div_val;
  logic [CW-1:0] clkdiv;
  logic [NCH-1:0] tick, ck;
  logic          step_tick;

  clkdiv_multi #(.CNT_W(CW), .NCH(NCH), .DIV_W(DW), .DEF_DIV(DEF), .DB_CYCLES(DB)) dut (
    .clk(clk), .rst(rst), .sel_step(sel_step), .pulse(pulse),
    .div_we(div_we), .div_sel(div_sel), .div_val(div_val),
    .clkdiv(clkdiv), .tick(tick), .ck(ck), .step_tick(step_tick)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0, n_fail = 0;
  int cyc = 0;

  // Model state: values expected during the current cycle.
  logic [CW-1:0]  m_clkdiv;
  logic [NCH-1:0] m_tick, m_ck;
  logic           m_step, m_mode, m_db, m_db_prev;
  int             m_el [NCH];   // cycles already spent in current period
  int             m_n  [NCH];
  int             m_pend [NCH];
  bit             m_pv [NCH];
  bit             hist [0:MAXC-1];
  int             rst_cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Advance the model by one cycle given this cycle's inputs.
  task automatic model_step(input bit r, input bit s, input bit p, input bit w,
                            input int sel_i, input int val_i);
    logic [NCH-1:0] nt;
    bit fire, all_diff;
    int period;
    hist[cyc] = p;
    if (r) begin
      m_clkdiv = '0; m_tick = '0; m_ck = '0; m_step = 1'b0;
      m_mode = 1'b0; m_db = 1'b0; m_db_prev = 1'b0;
      for (int i = 0; i < NCH; i++) begin
        m_el[i] = 0; m_n[i] = DEF; m_pend[i] = 0; m_pv[i] = 0;
      end
      // The synchroniser clears, so the two samples in flight read as 0.
      hist[cyc] = 1'b0;
      if (cyc > 0) hist[cyc-1] = 1'b0;
      rst_cyc = cyc;
    end else begin
      fire = m_db & ~m_db_prev;
      nt = '0;
      for (int i = 0; i < NCH; i++) begin
        if (m_mode) begin
          nt[i] = fire;
        end else begin
          period = (m_n[i] <= 1) ? 1 : m_n[i];
          if (m_el[i] + 1 >= period) begin
            nt[i] = 1'b1;
            m_el[i] = 0;
            if (m_pv[i]) begin m_n[i] = m_pend[i]; m_pv[i] = 0; end
          end else begin
            m_el[i]++;
          end
        end
        if (w && sel_i == i) begin m_pend[i] = val_i; m_pv[i] = 1; end
      end
      m_tick = nt;
      m_ck = m_ck ^ nt;
      m_step = fire;
      m_clkdiv = m_clkdiv + 1'b1;
      // db flips when the last DB synchronised samples (pulse delayed by 2)
      // taken since reset all disagree with it.
      m_db_prev = m_db;
      if (cyc - DB + 1 > rst_cyc) begin
        all_diff = 1'b1;
        for (int k = cyc - DB - 1; k <= cyc - 2; k++)
          if (hist[k] == m_db) all_diff = 1'b0;
        if (all_diff) m_db = ~m_db;
      end
      m_mode = s;
    end
    cyc++;
  endtask

  // Drive one cycle of inputs, step the model, then compare after the edge.
  task automatic drive(input bit r, input bit s, input bit p, input bit w,
                       input int sel_i, input int val_i);
    rst = r; sel_step = s; pulse = p; div_we = w;
    div_sel = SW'(sel_i); div_val = DW'(val_i);
    model_step(r, s, p, w, sel_i, val_i);
    @(posedge clk);
    #1;
    check("clkdiv", 32'(clkdiv), 32'(m_clkdiv));
    check("tick", 32'(tick), 32'(m_tick));
    check("ck", 32'(ck), 32'(m_ck));
    check("step_tick", 32'(step_tick), 32'(m_step));
  endtask

  initial begin
    int c_step, c_t1, c_t0;
    int c_tick [NCH];
    int c_ck [NCH];
    logic [NCH-1:0] ck_prev;
    bit s_r, p_r;

    // Reset and run with the default divisor of 4.
    for (int k = 0; k < 3; k++) drive(1, 0, 0, 0, 0, 0);
    check("rst_clkdiv", 32'(clkdiv), 32'd0);
    check("rst_ck", 32'(ck), 32'd0);
    for (int k = 0; k < 9; k++) begin
      drive(0, 0, 0, 0, 0, 0);
      check("boot_clkdiv", 32'(clkdiv), 32'(k + 1));
      check("boot_tick", 32'(tick), (k + 1 == 4 || k + 1 == 8) ? 32'hF : 32'h0);
    end

    // Channel 1 reprogrammed to 3 while its count is 1.
    drive(0, 0, 0, 1, 1, 3);
    c_t1 = 0; c_t0 = 0;
    for (int k = 0; k < 12; k++) begin
      drive(0, 0, 0, 0, 0, 0);
      c_t1 += int'(tick[1]);
      c_t0 += int'(tick[0]);
    end
    check("ch1_ticks_after_div3", 32'(c_t1), 32'd4);
    check("ch0_ticks_unchanged", 32'(c_t0), 32'd3);

    // Channel 2 with divisor 0, then 1.
    drive(0, 0, 0, 1, 2, 0);
    for (int k = 0; k < 10; k++) drive(0, 0, 0, 0, 0, 0);
    check("ch2_div0_tick", 32'(tick[2]), 32'd1);
    drive(0, 0, 0, 1, 2, 1);
    for (int k = 0; k < 10; k++) drive(0, 0, 0, 0, 0, 0);
    check("ch2_div1_tick", 32'(tick[2]), 32'd1);

    // Step mode: bouncing press, clean hold, bouncing release.
    drive(0, 1, 0, 0, 0, 0);
    c_step = 0;
    for (int i = 0; i < NCH; i++) begin c_tick[i] = 0; c_ck[i] = 0; end
    ck_prev = ck;
    for (int k = 0; k < 100; k++) begin
      if (k < 40)      drive(0, 1, bit'((k / 3) % 2), 0, 0, 0);
      else if (k < 70) drive(0, 1, 1, 0, 0, 0);
      else             drive(0, 1, bit'(((k - 70) / 3) % 2 == 0 && k < 85), 0, 0, 0);
      c_step += int'(step_tick);
      for (int i = 0; i < NCH; i++) begin
        c_tick[i] += int'(tick[i]);
        c_ck[i]   += int'(ck[i] != ck_prev[i]);
      end
      ck_prev = ck;
    end
    check("step_tick_count", 32'(c_step), 32'd1);
    for (int i = 0; i < NCH; i++) begin
      check("step_tick_per_ch", 32'(c_tick[i]), 32'd1);
      check("step_ck_toggles", 32'(c_ck[i]), 32'd1);
    end
    for (int k = 0; k < 10; k++) drive(0, 0, 0, 0, 0, 0);

    // Reset mid-period with a pending write outstanding.
    drive(0, 0, 0, 1, 0, 7);
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    check("midrst_tick", 32'(tick), 32'd0);
    check("midrst_clkdiv", 32'(clkdiv), 32'd0);
    for (int k = 0; k < 9; k++) begin
      drive(0, 0, 0, 0, 0, 0);
      check("midrst_tick_def", 32'(tick), (k + 1 == 4 || k + 1 == 8) ? 32'hF : 32'h0);
    end

    // Random traffic, long enough to wrap clkdiv several times.
    s_r = 1'b0; p_r = 1'b0;
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 99) == 0)  s_r = ~s_r;
      if ($urandom_range(0, 19) == 0)  p_r = ~p_r;
      drive(bit'($urandom_range(0, 199) == 0), s_r, p_r,
            bit'($urandom_range(0, 7) == 0), int'($urandom_range(0, NCH - 1)),
            int'($urandom_range(0, 9)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
